// File: rtl/dlx_pkg.sv
// Types and constants shared by the DLX fetch, decode and write-back blocks.
// Any block that needs the fetch sequencer's state encoding imports it from here.
package dlx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    HALT
  } fetch_state_t;

  localparam int          INSTR_BYTES = 4;
  localparam logic [31:0] DLX_NOP     = 32'h0000_0000;

  // Instruction addresses must sit on a word boundary.
  function automatic logic word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// Counts FETCH cycles spent waiting on instruction memory.
// expired is high during the cycle in which the count equals TIMEOUT-1.
module fetch_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int            CW   = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;

  // Holding at LAST keeps the counter from wrapping if the owner lingers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (en && !expired) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign expired = (r_count == LAST);

endmodule

// File: rtl/fetch_unit.sv
// Multicycle DLX fetch stage: owns the PC, reads instruction memory, strobes the
// decoder once per instruction and advances or redirects the PC at retirement.
module fetch_unit
  import dlx_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  output logic [31:0]  i_address,
  output logic         i_read,
  input  logic         i_ready,
  input  logic [31:0]  i_data_read,
  output logic [31:0]  instr,
  output logic         ID,
  input  logic         done,
  input  logic         pc_load,
  input  logic [31:0]  pc_target,
  output logic [31:0]  pc_next,
  output logic         fault,
  output fetch_state_t o_dbg_state
);

  // Memory handshake: i_read is held for the whole FETCH state and a word is taken
  // on any cycle where i_read and i_ready are both high; there is no back-pressure
  // on the reply side. The decoder gets ID for one cycle; done closes EXEC.

  fetch_state_t r_state;
  fetch_state_t w_next_state;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_d;
  logic [31:0]  r_instr;
  logic [31:0]  w_instr_d;
  logic         r_fault;
  logic         w_fault_d;
  logic         r_run;
  logic         w_expired;
  logic         w_cnt_clear;
  logic         w_cnt_en;

  // Release synchroniser: leaves IDLE only once reset release has been seen by a clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  assign w_cnt_clear = (r_state != FETCH);
  assign w_cnt_en    = (r_state == FETCH) && !i_ready;

  fetch_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (w_cnt_clear),
    .en      (w_cnt_en),
    .expired (w_expired)
  );

  always_comb begin
    w_next_state = r_state;
    w_pc_d       = r_pc;
    w_instr_d    = r_instr;
    w_fault_d    = r_fault;
    case (r_state)
      IDLE: begin
        if (r_run) begin
          w_next_state = FETCH;
        end
      end
      FETCH: begin
        // A reply on the last permitted cycle still completes the fetch.
        if (i_ready) begin
          w_instr_d    = i_data_read;
          w_next_state = DECODE;
        end else if (w_expired) begin
          w_fault_d    = 1'b1;
          w_next_state = HALT;
        end
      end
      DECODE: begin
        w_next_state = EXEC;
      end
      EXEC: begin
        if (done) begin
          if (!pc_load) begin
            w_pc_d       = r_pc + 32'(INSTR_BYTES);
            w_next_state = FETCH;
          end else if (word_aligned(pc_target)) begin
            w_pc_d       = pc_target;
            w_next_state = FETCH;
          end else begin
            w_fault_d    = 1'b1;
            w_next_state = HALT;
          end
        end
      end
      HALT: begin
        w_next_state = HALT;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_instr <= DLX_NOP;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_pc_d;
      r_instr <= w_instr_d;
      r_fault <= w_fault_d;
    end
  end

  assign i_address   = r_pc;
  assign i_read      = (r_state == FETCH);
  assign ID          = (r_state == DECODE);
  assign instr       = r_instr;
  assign pc_next     = r_pc + 32'(INSTR_BYTES);
  assign fault       = r_fault;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: two instances (RESET_PC 0 and 32'hFFFF_FFFC) share all inputs.
// Directed table, hand-written corner sequences, then randomised instruction traffic.
module tb_fetch_unit;
  import dlx_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        i_ready;
  logic [31:0] i_data_read;
  logic        done;
  logic        pc_load;
  logic [31:0] pc_target;

  logic [31:0] a_addr, a_instr, a_pc_next;
  logic        a_read, a_id, a_fault;
  fetch_state_t a_state;
  logic [31:0] b_addr, b_instr, b_pc_next;
  logic        b_read, b_id, b_fault;
  fetch_state_t b_state;

  fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n), .i_address(a_addr), .i_read(a_read),
    .i_ready(i_ready), .i_data_read(i_data_read), .instr(a_instr), .ID(a_id),
    .done(done), .pc_load(pc_load), .pc_target(pc_target), .pc_next(a_pc_next),
    .fault(a_fault), .o_dbg_state(a_state)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT(16)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .i_address(b_addr), .i_read(b_read),
    .i_ready(i_ready), .i_data_read(i_data_read), .instr(b_instr), .ID(b_id),
    .done(done), .pc_load(pc_load), .pc_target(pc_target), .pc_next(b_pc_next),
    .fault(b_fault), .o_dbg_state(b_state)
  );

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] model_pc;

  typedef struct {
    int          lat;
    logic [31:0] data;
    logic        load;
    logic [31:0] target;
    logic [31:0] exp_addr;
    logic [31:0] exp_pc_next;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic wait_read(input string name);
    int k = 0;
    while (!a_read && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({name, "_fetch_start"}, 32'(a_read), 32'd1);
  endtask

  // One instruction: reply after lat wait cycles, retire after exec_wait cycles.
  task automatic do_fetch(input int lat, input logic [31:0] data, input int exec_wait,
                          input logic load, input logic [31:0] target, input bit junk);
    wait_read("xact");
    check("i_address", a_addr, model_pc);
    check("pc_next", a_pc_next, model_pc + 32'd4);
    for (int k = 0; k < lat; k++) begin
      i_ready = 1'b0;
      if (junk) begin
        done      = 1'($urandom_range(0, 1));
        pc_load   = 1'($urandom_range(0, 1));
        pc_target = $urandom;
      end
      @(negedge clk);
    end
    i_ready     = 1'b1;
    i_data_read = data;
    @(negedge clk);
    i_ready     = 1'b0;
    done        = 1'b0;
    pc_load     = 1'b0;
    i_data_read = $urandom;
    check("id_strobe", 32'(a_id), 32'd1);
    check("instr", a_instr, data);
    check("read_in_decode", 32'(a_read), 32'd0);
    @(negedge clk);
    check("id_single_cycle", 32'(a_id), 32'd0);
    for (int k = 0; k < exec_wait; k++) begin
      pc_load   = 1'($urandom_range(0, 1));
      pc_target = $urandom;
      @(negedge clk);
      check("read_in_exec", 32'(a_read), 32'd0);
    end
    done      = 1'b1;
    pc_load   = load;
    pc_target = target;
    @(negedge clk);
    done    = 1'b0;
    pc_load = 1'b0;
    if (!load) model_pc = model_pc + 32'd4;
    else if (target[1:0] == 2'b00) model_pc = target;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    i_ready = 1'b0;
    done    = 1'b0;
    pc_load = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          cnt;
    logic [31:0] t;
    logic [31:0] hdata;

    vecs[0] = '{1,  32'h2008_1234, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0004};
    vecs[1] = '{0,  32'h8C22_0004, 1'b0, 32'h0000_0000, 32'h0000_0004, 32'h0000_0008};
    vecs[2] = '{3,  32'hAC43_0008, 1'b0, 32'h0000_0000, 32'h0000_0008, 32'h0000_000C};
    vecs[3] = '{0,  32'h2001_0010, 1'b0, 32'h0000_0000, 32'h0000_000C, 32'h0000_0010};
    vecs[4] = '{2,  32'h1000_0040, 1'b1, 32'h0000_0100, 32'h0000_0010, 32'h0000_0014};
    vecs[5] = '{0,  32'h0800_00FC, 1'b1, 32'h0000_0200, 32'h0000_0100, 32'h0000_0104};
    vecs[6] = '{15, 32'h4C20_0000, 1'b0, 32'h0000_0000, 32'h0000_0200, 32'h0000_0204};
    vecs[7] = '{5,  32'h1441_FFFE, 1'b0, 32'h0000_0000, 32'h0000_0204, 32'h0000_0208};

    reset_n     = 1'b0;
    i_ready     = 1'b0;
    i_data_read = 32'h0;
    done        = 1'b0;
    pc_load     = 1'b0;
    pc_target   = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_i_read", 32'(a_read), 32'd0);
    check("rst_id", 32'(a_id), 32'd0);
    check("rst_instr", a_instr, 32'h0);
    check("rst_fault", 32'(a_fault), 32'd0);
    check("rst_i_address", a_addr, 32'h0);
    check("rst_pc_next", a_pc_next, 32'h4);
    check("rst_wrap_i_address", b_addr, 32'hFFFF_FFFC);
    check("rst_wrap_pc_next", b_pc_next, 32'h0);

    reset_n = 1'b1;
    @(negedge clk);
    check("dead_cycle_read", 32'(a_read), 32'd0);
    @(negedge clk);
    check("read_2nd_edge", 32'(a_read), 32'd1);

    model_pc = 32'h0;
    for (int r = 0; r < 8; r++) begin
      check("tbl_i_address", a_addr, vecs[r].exp_addr);
      check("tbl_pc_next", a_pc_next, vecs[r].exp_pc_next);
      do_fetch(vecs[r].lat, vecs[r].data, 1 + (r % 3), vecs[r].load, vecs[r].target, 1'b1);
      if (r == 0) begin
        check("wrap_i_address", b_addr, 32'h0);
        check("wrap_pc_next", b_pc_next, 32'h4);
      end
    end

    // Misaligned redirect halts with a sticky fault and an unchanged PC.
    hdata = 32'h0C00_0102;
    do_fetch(0, hdata, 0, 1'b1, 32'h0000_0102, 1'b0);
    for (int k = 0; k < 20; k++) begin
      check("misalign_fault", 32'(a_fault), 32'd1);
      check("misalign_read", 32'(a_read), 32'd0);
      check("misalign_pc", a_addr, 32'h0000_0208);
      @(negedge clk);
    end
    check("halt_id", 32'(a_id), 32'd0);
    check("halt_instr", a_instr, hdata);
    reset_n = 1'b0;
    #1;
    check("reset_clears_fault", 32'(a_fault), 32'd0);
    pulse_reset();

    // Memory never replies: 16 cycles of i_read, then fault.
    wait_read("timeout");
    cnt = 0;
    while (a_read && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    check("timeout_read_cycles", 32'(cnt), 32'd16);
    check("timeout_fault", 32'(a_fault), 32'd1);
    check("timeout_id", 32'(a_id), 32'd0);
    pulse_reset();

    // Reset mid-FETCH drops i_read without a clock edge; a late reply is discarded.
    wait_read("midreset");
    repeat (2) @(negedge clk);
    #2;
    reset_n     = 1'b0;
    i_ready     = 1'b1;
    i_data_read = 32'hDEAD_BEEF;
    #1;
    check("midreset_read", 32'(a_read), 32'd0);
    check("midreset_wrap_read", 32'(b_read), 32'd0);
    @(negedge clk);
    i_ready = 1'b0;
    reset_n = 1'b1;
    wait_read("restart");
    check("restart_i_address", a_addr, 32'h0);
    check("restart_wrap_i_address", b_addr, 32'hFFFF_FFFC);
    check("restart_instr", a_instr, 32'h0);
    check("restart_fault", 32'(a_fault), 32'd0);

    model_pc = 32'h0;
    for (int n = 0; n < 40; n++) begin
      t = $urandom;
      t[1:0] = 2'b00;
      do_fetch($urandom_range(0, 15), $urandom, $urandom_range(0, 3),
               ($urandom_range(0, 2) == 0), t, 1'b1);
    end
    wait_read("final");
    check("final_i_address", a_addr, model_pc);
    check("final_fault", 32'(a_fault), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
